// File: rtl/somador_pkg.sv
// somador_pkg: shared definitions for the sign-magnitude adder result stage.
//   - state_t      : packer FSM state encoding
//   - N_DEF        : default two's-complement result width
//   - MAX_POS(n)   : largest positive n-bit two's-complement value (32-bit result)
//   - MIN_NEG(n)   : bit pattern / magnitude of the most negative n-bit value (32-bit result)
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int N_DEF = 8;

  function automatic logic [31:0] MAX_POS(input int unsigned n);
    MAX_POS = (32'd1 << (n - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [31:0] MIN_NEG(input int unsigned n);
    MIN_NEG = 32'd1 << (n - 32'd1);
  endfunction

endpackage

// File: rtl/sm2c_conv.sv
// sm2c_conv: combinational sign+magnitude to two's complement conversion.
// Ports:
//   sign : 1 = negative
//   mag  : MAG_W-bit magnitude (includes the adder carry bit)
//   res  : N-bit two's-complement result
//   ovf  : value lies outside the N-bit two's-complement range
// Build option: RESULT_C2_SATURATE_EN clamps res on overflow; otherwise res
// carries the low N bits of the wrapped conversion.
module sm2c_conv
  import somador_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int MAG_W = N + 1
) (
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  output logic [N-1:0]     res,
  output logic             ovf
);

  localparam logic [31:0]      MAX_POS_W = MAX_POS(N);
  localparam logic [31:0]      MIN_NEG_W = MIN_NEG(N);
  localparam logic [MAG_W-1:0] POS_LIM   = MAX_POS_W[MAG_W-1:0];
  localparam logic [MAG_W-1:0] NEG_LIM   = MIN_NEG_W[MAG_W-1:0];
  localparam logic [N-1:0]     SAT_POS   = MAX_POS_W[N-1:0];
  localparam logic [N-1:0]     SAT_NEG   = MIN_NEG_W[N-1:0];

  logic [MAG_W-1:0] neg_s;
  logic [N-1:0]     wrap_s;

  // Wrapped conversion and range check; zero of either sign maps to +0.
  always_comb begin
    neg_s  = ~mag + {{(MAG_W-1){1'b0}}, 1'b1};
    wrap_s = {N{1'b0}};
    ovf    = 1'b0;
    if (mag == {MAG_W{1'b0}}) begin
      wrap_s = {N{1'b0}};
      ovf    = 1'b0;
    end else if (sign) begin
      wrap_s = neg_s[N-1:0];
      ovf    = (mag > NEG_LIM);
    end else begin
      wrap_s = mag[N-1:0];
      ovf    = (mag > POS_LIM);
    end
  end

`ifdef RESULT_C2_SATURATE_EN
  // Clamp toward the representable extreme matching the sign.
  assign res = ovf ? (sign ? SAT_NEG : SAT_POS) : wrap_s;
`else
  assign res = wrap_s;
`endif

endmodule

// File: rtl/result_c2_packer.sv
// result_c2_packer: captures the adder sign+magnitude result on the rising
// edge of done_in, converts it to two's complement, flags overflow and holds
// it under a valid/ack handshake.
// Ports:
//   clk, RESET_n       : clock (rising edge), asynchronous active-low reset
//   done_in            : adder done level (stays high once set)
//   res_sign, res_mag  : adder result sign and (N+1)-bit magnitude
//   ready_out          : stage idle, upstream may start a new operation
//   valid, ack         : result handshake (ack only honoured while valid)
//   res_c2, ovf        : registered result and overflow flag
//   lost               : sticky, a done edge arrived while busy
// Build option: RESULT_C2_SATURATE_EN (see sm2c_conv) clamps on overflow.
module result_c2_packer
  import somador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         RESET_n,
  input  logic         done_in,
  input  logic         res_sign,
  input  logic [N:0]   res_mag,
  output logic         ready_out,
  output logic         valid,
  input  logic         ack,
  output logic [N-1:0] res_c2,
  output logic         ovf,
  output logic         lost
);

  localparam int MAG_W = N + 1;

  state_t           state_r, state_nxt_s;
  logic             done_q_r;
  logic             event_s;
  logic             sign_r;
  logic [MAG_W-1:0] mag_r;
  logic [N-1:0]     conv_res_s;
  logic             conv_ovf_s;

  sm2c_conv #(.N(N), .MAG_W(MAG_W)) u_conv (
    .sign (sign_r),
    .mag  (mag_r),
    .res  (conv_res_s),
    .ovf  (conv_ovf_s)
  );

  // done_q resets high so a done level already present at reset is not an edge.
  assign event_s   = done_in & ~done_q_r;
  assign ready_out = (state_r == IDLE);

  // Done edge detector.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      done_q_r <= 1'b1;
    end else begin
      done_q_r <= done_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; ack only matters in HOLD, which is exactly when valid is high.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (event_s) begin
          state_nxt_s = CONVERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONVERT: state_nxt_s = HOLD;
      HOLD: begin
        if (ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Capture, result and handshake registers.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      sign_r <= 1'b0;
      mag_r  <= {MAG_W{1'b0}};
      res_c2 <= {N{1'b0}};
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (event_s) begin
            sign_r <= res_sign;
            mag_r  <= res_mag;
          end
        end
        CONVERT: begin
          res_c2 <= conv_res_s;
          ovf    <= conv_ovf_s;
          valid  <= 1'b1;
        end
        HOLD: begin
          if (ack) begin
            valid <= 1'b0;
          end
        end
        default: valid <= 1'b0;
      endcase
    end
  end

  // Sticky overrun flag: an edge while busy is dropped and remembered.
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      lost <= 1'b0;
    end else if (event_s && (state_r != IDLE)) begin
      lost <= 1'b1;
    end
  end

endmodule
